// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register: captures decoded fields and bypassed operands at the end of ID,
// forces x0 reads to zero, detects load-use hazards and counts the EX bubbles it inserts.
module id_ex_pipe_reg #(
  parameter int XLEN         = 32,
  parameter int CTRL_W       = 12,
  parameter int MEM_READ_BIT = 0,
  parameter int CNT_W        = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic [4:0]        id_rd,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [XLEN-1:0]   rf_rdata1,
  input  logic [XLEN-1:0]   rf_rdata2,
  input  logic              wb_wen,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb_wdata,
  output logic              ld_use_stall,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_rs1_val,
  output logic [XLEN-1:0]   ex_rs2_val,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [XLEN-1:0]   ex_imm,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  bubble_count
);

  typedef struct packed {
    logic              valid;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [4:0]        rd;
    logic [XLEN-1:0]   imm;
    logic [CTRL_W-1:0] ctrl;
  } ex_t;

  ex_t             ex_q;
  ex_t             id_bundle;
  logic [CNT_W-1:0] bubble_q;

  // x0 wins over everything; otherwise a same-edge writeback beats the stale regfile read.
  function automatic logic [XLEN-1:0] sel_operand(
    input logic [4:0]      src,
    input logic [XLEN-1:0] rf_data,
    input logic            wen,
    input logic [4:0]      wrd,
    input logic [XLEN-1:0] wdata
  );
    if (src == 5'd0)
      return '0;
    else if (wen && (wrd == src))
      return wdata;
    else
      return rf_data;
  endfunction

  always_comb begin
    id_bundle         = '0;
    id_bundle.valid   = id_valid;
    id_bundle.pc      = id_pc;
    id_bundle.rs1_val = sel_operand(id_rs1, rf_rdata1, wb_wen, wb_rd, wb_wdata);
    id_bundle.rs2_val = sel_operand(id_rs2, rf_rdata2, wb_wen, wb_rd, wb_wdata);
    id_bundle.rs1     = id_rs1;
    id_bundle.rs2     = id_rs2;
    id_bundle.rd      = id_rd;
    id_bundle.imm     = id_imm;
    id_bundle.ctrl    = id_valid ? id_ctrl : '0;
  end

  // A bubble has ex_valid=0, so it can never re-trigger the hazard on the next cycle.
  assign ld_use_stall = id_valid & ex_q.valid & ex_q.ctrl[MEM_READ_BIT] & (ex_q.rd != 5'd0)
                      & ((ex_q.rd == id_rs1) | (ex_q.rd == id_rs2)) & ~flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ex_q     <= '0;
      bubble_q <= '0;
    end else if (flush) begin
      ex_q <= '0;
    end else if (stall) begin
      ex_q <= ex_q;
    end else if (ld_use_stall) begin
      ex_q <= '0;
      if (bubble_q != '1)
        bubble_q <= bubble_q + 1'b1;
    end else begin
      ex_q <= id_bundle;
    end
  end

  assign ex_valid     = ex_q.valid;
  assign ex_pc        = ex_q.pc;
  assign ex_rs1_val   = ex_q.rs1_val;
  assign ex_rs2_val   = ex_q.rs2_val;
  assign ex_rs1       = ex_q.rs1;
  assign ex_rs2       = ex_q.rs2;
  assign ex_rd        = ex_q.rd;
  assign ex_imm       = ex_q.imm;
  assign ex_ctrl      = ex_q.ctrl;
  assign bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Scoreboard bench for id_ex_pipe_reg: directed vectors push hand-computed EX state,
// a monitor pops and compares after each rising edge. A CNT_W=2 twin checks saturation.
module tb_id_ex_pipe_reg;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall, flush, id_valid;
  logic [31:0] id_pc, id_imm, rf_rdata1, rf_rdata2, wb_wdata;
  logic [4:0]  id_rs1, id_rs2, id_rd, wb_rd;
  logic [11:0] id_ctrl;
  logic        wb_wen;

  logic        ld_use_stall, ex_valid;
  logic [31:0] ex_pc, ex_rs1_val, ex_rs2_val, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [11:0] ex_ctrl;
  logic [15:0] bubble_count;

  logic        s_lus, s_valid;
  logic [31:0] s_pc, s_rs1_val, s_rs2_val, s_imm;
  logic [4:0]  s_rs1, s_rs2, s_rd;
  logic [11:0] s_ctrl;
  logic [1:0]  s_bubble_count;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  id_ex_pipe_reg dut (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_wen(wb_wen),
    .wb_rd(wb_rd), .wb_wdata(wb_wdata), .ld_use_stall(ld_use_stall), .ex_valid(ex_valid),
    .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val), .ex_rs1(ex_rs1),
    .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_imm(ex_imm), .ex_ctrl(ex_ctrl),
    .bubble_count(bubble_count)
  );

  id_ex_pipe_reg #(.CNT_W(2)) dut_sat (
    .clock(clock), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_pc(id_pc), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2), .wb_wen(wb_wen),
    .wb_rd(wb_rd), .wb_wdata(wb_wdata), .ld_use_stall(s_lus), .ex_valid(s_valid),
    .ex_pc(s_pc), .ex_rs1_val(s_rs1_val), .ex_rs2_val(s_rs2_val), .ex_rs1(s_rs1),
    .ex_rs2(s_rs2), .ex_rd(s_rd), .ex_imm(s_imm), .ex_ctrl(s_ctrl),
    .bubble_count(s_bubble_count)
  );

  typedef struct {
    logic        stall, flush, valid;
    logic [31:0] pc;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [11:0] ctrl;
    logic [31:0] rd1, rd2;
    logic        wen;
    logic [4:0]  wrd;
    logic [31:0] wdata;
  } in_t;

  typedef struct {
    int          id;
    logic        valid;
    logic [31:0] pc, rs1v, rs2v;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic [11:0] ctrl;
    logic [15:0] cnt;
    logic [1:0]  sat;
  } exp_t;

  exp_t sb[$];
  int   vec_id = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic in_t mk_in(
    input logic s, f, v, input logic [31:0] pc, input logic [4:0] rs1, rs2, rd,
    input logic [31:0] imm, input logic [11:0] ctrl, input logic [31:0] rd1, rd2,
    input logic wen, input logic [4:0] wrd, input logic [31:0] wdata);
    in_t r;
    r.stall = s; r.flush = f; r.valid = v; r.pc = pc; r.rs1 = rs1; r.rs2 = rs2; r.rd = rd;
    r.imm = imm; r.ctrl = ctrl; r.rd1 = rd1; r.rd2 = rd2; r.wen = wen; r.wrd = wrd;
    r.wdata = wdata;
    return r;
  endfunction

  function automatic exp_t mk_exp(
    input logic v, input logic [31:0] pc, rs1v, rs2v, input logic [4:0] rs1, rs2, rd,
    input logic [31:0] imm, input logic [11:0] ctrl, input logic [15:0] cnt,
    input logic [1:0] sat);
    exp_t e;
    e.id = 0; e.valid = v; e.pc = pc; e.rs1v = rs1v; e.rs2v = rs2v; e.rs1 = rs1;
    e.rs2 = rs2; e.rd = rd; e.imm = imm; e.ctrl = ctrl; e.cnt = cnt; e.sat = sat;
    return e;
  endfunction

  task automatic drive(input in_t v);
    stall = v.stall; flush = v.flush; id_valid = v.valid; id_pc = v.pc;
    id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd; id_imm = v.imm; id_ctrl = v.ctrl;
    rf_rdata1 = v.rd1; rf_rdata2 = v.rd2; wb_wen = v.wen; wb_rd = v.wrd; wb_wdata = v.wdata;
  endtask

  task automatic apply_now(input in_t v, input logic lus, input exp_t e);
    drive(v);
    #1;
    vec_id++;
    check($sformatf("v%0d_ld_use_stall", vec_id), ld_use_stall, lus);
    e.id = vec_id;
    sb.push_back(e);
  endtask

  task automatic apply(input in_t v, input logic lus, input exp_t e);
    @(negedge clock);
    apply_now(v, lus, e);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ex_valid"}, ex_valid, 0);
    check({tag, "_ex_pc"}, ex_pc, 0);
    check({tag, "_ex_rs1_val"}, ex_rs1_val, 0);
    check({tag, "_ex_rs2_val"}, ex_rs2_val, 0);
    check({tag, "_ex_idx"}, {ex_rs1, ex_rs2, ex_rd}, 0);
    check({tag, "_ex_imm"}, ex_imm, 0);
    check({tag, "_ex_ctrl"}, ex_ctrl, 0);
    check({tag, "_bubble_count"}, bubble_count, 0);
    check({tag, "_ld_use_stall"}, ld_use_stall, 0);
    check({tag, "_sat_state"}, {s_valid, s_pc, s_ctrl, s_bubble_count}, 0);
  endtask

  // Monitor: compares EX state after every rising edge for which a vector was issued.
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check($sformatf("v%0d_ex_valid", e.id), ex_valid, e.valid);
        check($sformatf("v%0d_ex_pc", e.id), ex_pc, e.pc);
        check($sformatf("v%0d_ex_rs1_val", e.id), ex_rs1_val, e.rs1v);
        check($sformatf("v%0d_ex_rs2_val", e.id), ex_rs2_val, e.rs2v);
        check($sformatf("v%0d_ex_rs1", e.id), ex_rs1, e.rs1);
        check($sformatf("v%0d_ex_rs2", e.id), ex_rs2, e.rs2);
        check($sformatf("v%0d_ex_rd", e.id), ex_rd, e.rd);
        check($sformatf("v%0d_ex_imm", e.id), ex_imm, e.imm);
        check($sformatf("v%0d_ex_ctrl", e.id), ex_ctrl, e.ctrl);
        check($sformatf("v%0d_bubble_count", e.id), bubble_count, e.cnt);
        check($sformatf("v%0d_sat_count", e.id), s_bubble_count, e.sat);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic drain();
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(posedge clock);
    #2;
    check("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    exp_t bub;
    reset = 1'b0;
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    // Reset held while inputs toggle.
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      drive(mk_in($urandom, $urandom, 1, $urandom, 5'($urandom), 5'($urandom),
                  5'($urandom), $urandom, 12'($urandom), $urandom, $urandom, 1,
                  5'($urandom), $urandom));
      @(posedge clock);
      #1;
      check_all_zero($sformatf("reset%0d", i));
    end
    @(negedge clock);
    drive(mk_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    reset = 1'b1;

    apply(mk_in(0, 0, 1, 'h100, 5, 6, 7, 'h10, 'h002, 'hD, 'h22, 0, 0, 0), 0,
          mk_exp(1, 'h100, 'hD, 'h22, 5, 6, 7, 'h10, 'h002, 0, 0));
    // WB bypass hit, then miss on a different rd.
    apply(mk_in(0, 0, 1, 'h104, 3, 6, 9, 0, 'h004, 'h56, 'h22, 1, 3, 'h1234), 0,
          mk_exp(1, 'h104, 'h1234, 'h22, 3, 6, 9, 0, 'h004, 0, 0));
    apply(mk_in(0, 0, 1, 'h108, 3, 6, 9, 0, 'h004, 'h56, 'h22, 1, 4, 'h1234), 0,
          mk_exp(1, 'h108, 'h56, 'h22, 3, 6, 9, 0, 'h004, 0, 0));
    // x0 source with a writeback to x0.
    apply(mk_in(0, 0, 1, 'h10C, 3, 0, 0, 0, 0, 'h56, 'hFFFF, 1, 0, 7), 0,
          mk_exp(1, 'h10C, 'h56, 0, 3, 0, 0, 0, 0, 0, 0));
    // Load rd=8, then a dependent on rs2: one bubble, then the dependent enters.
    apply(mk_in(0, 0, 1, 'h110, 1, 2, 8, 4, 'h001, 'h1000, 0, 0, 0, 0), 0,
          mk_exp(1, 'h110, 'h1000, 0, 1, 2, 8, 4, 'h001, 0, 0));
    bub = mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    apply(mk_in(0, 0, 1, 'h114, 9, 8, 10, 0, 'h008, 'hA, 'hB, 0, 0, 0), 1, bub);
    apply(mk_in(0, 0, 1, 'h114, 9, 8, 10, 0, 'h008, 'hA, 'hB, 0, 0, 0), 0,
          mk_exp(1, 'h114, 'hA, 'hB, 9, 8, 10, 0, 'h008, 1, 1));
    // Load rd=12, then flush+stall with a hazard-shaped ID: flush wins, count unchanged.
    apply(mk_in(0, 0, 1, 'h118, 1, 2, 12, 0, 'h001, 'h20, 'h30, 0, 0, 0), 0,
          mk_exp(1, 'h118, 'h20, 'h30, 1, 2, 12, 0, 'h001, 1, 1));
    apply(mk_in(1, 1, 1, 'h11C, 12, 12, 3, 0, 'h008, 1, 2, 0, 0, 0), 0,
          mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    // Load rd=12, then stall for 3 cycles with a dependent in ID: EX holds.
    apply(mk_in(0, 0, 1, 'h11C, 0, 0, 12, 0, 'h001, 5, 6, 0, 0, 0), 0,
          mk_exp(1, 'h11C, 0, 0, 0, 0, 12, 0, 'h001, 1, 1));
    for (int k = 0; k < 3; k++)
      apply(mk_in(1, 0, 1, 'h120 + 4 * k, 12, 5'(k + 1), 13, k, 'h008, 'h77, 'h88, 1, 12, 'h99),
            1, mk_exp(1, 'h11C, 0, 0, 0, 0, 12, 0, 'h001, 1, 1));
    apply(mk_in(0, 0, 1, 'h120, 12, 3, 13, 0, 'h008, 'h77, 'h88, 0, 0, 0), 1,
          mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 2));
    // Three more load/dependent pairs: bubbles 3..5, CNT_W=2 twin pins at 3.
    for (int k = 0; k < 3; k++) begin
      apply(mk_in(0, 0, 1, 'h200 + 8 * k, 1, 2, 12, 0, 'h001, 'h20, 'h30, 0, 0, 0), 0,
            mk_exp(1, 'h200 + 8 * k, 'h20, 'h30, 1, 2, 12, 0, 'h001, 16'(2 + k),
                   (k == 0) ? 2'd2 : 2'd3));
      apply(mk_in(0, 0, 1, 'h204 + 8 * k, 12, 5, 14, 0, 'h008, 1, 2, 0, 0, 0), 1,
            mk_exp(0, 0, 0, 0, 0, 0, 0, 0, 0, 16'(3 + k), 2'd3));
    end
    // Invalid ID instruction: ctrl zeroed, other fields still captured.
    apply(mk_in(0, 0, 0, 'h300, 4, 0, 5, 9, 'hFFF, 'h44, 'h55, 0, 0, 0), 0,
          mk_exp(0, 'h300, 'h44, 0, 4, 0, 5, 9, 0, 5, 3));
    // Load to x0 never causes a hazard.
    apply(mk_in(0, 0, 1, 'h304, 0, 0, 0, 0, 'h001, 0, 0, 0, 0, 0), 0,
          mk_exp(1, 'h304, 0, 0, 0, 0, 0, 0, 'h001, 5, 3));
    apply(mk_in(0, 0, 1, 'h308, 0, 0, 6, 0, 'h002, 'h11, 'h22, 0, 0, 0), 0,
          mk_exp(1, 'h308, 0, 0, 0, 0, 6, 0, 'h002, 5, 3));
    drain();

    // Reset mid-stall clears outputs before the next rising edge.
    @(negedge clock);
    drive(mk_in(1, 0, 1, 'h30C, 1, 2, 3, 0, 'h001, 1, 2, 0, 0, 0));
    #2;
    reset = 1'b0;
    #1;
    check_all_zero("async_reset");

    // First edge after release is a normal load.
    @(negedge clock);
    reset = 1'b1;
    apply_now(mk_in(0, 0, 1, 'h400, 5, 0, 1, 0, 0, 'hD, 0, 0, 0, 0), 0,
              mk_exp(1, 'h400, 'hD, 0, 5, 0, 1, 0, 0, 0, 0));
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
